// File: rtl/axis_video_pkg.sv
// rtl/axis_video_pkg.sv - shared state encoding and counter width for the AXIS video blocks
package axis_video_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/axis_video_raster_cnt.sv
// rtl/axis_video_raster_cnt.sv - h/v raster counters with sof/eol/eof decodes
module axis_video_raster_cnt
    import axis_video_pkg::*;
#(
    parameter int OUT_W = 1920,
    parameter int OUT_H = 1080
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             clear,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             sof,
    output logic             eol,
    output logic             eof
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(OUT_H - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    assign sof = (h_cnt == '0) && (v_cnt == '0);
    assign eol = (h_cnt == H_LAST);
    assign eof = eol && (v_cnt == V_LAST);

    // clear wins over advance so a new frame always starts at the origin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (clear) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (advance) begin
            if (eol) begin
                h_cnt <= '0;
                v_cnt <= eof ? '0 : v_cnt + ONE;
            end else begin
                h_cnt <= h_cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/axis_video_pad.sv
// rtl/axis_video_pad.sv - embeds a small AXIS video frame into a larger canvas with a border colour
// Optional status outputs (frame_cnt, resync_cnt, tlast_err) under AXIS_VIDEO_PAD_STATUS_EN.
module axis_video_pad
    import axis_video_pkg::*;
#(
    parameter int VIDEO_IN_W  = 640,
    parameter int VIDEO_IN_H  = 480,
    parameter int VIDEO_OUT_W = 1920,
    parameter int VIDEO_OUT_H = 1080,
    parameter int H_OFFSET    = 640,
    parameter int V_OFFSET    = 300,
    parameter int DATA_WIDTH  = 24,
    parameter int USER_WIDTH  = 1,
    parameter logic [DATA_WIDTH-1:0] BORDER_COLOR = {DATA_WIDTH{1'b0}}
) (
    input  logic                  axis_clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser
`ifdef AXIS_VIDEO_PAD_STATUS_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           resync_cnt,
    output logic                  tlast_err
`endif
);

    localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_OFFSET);
    localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_OFFSET + VIDEO_IN_W - 1);
    localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_OFFSET);
    localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_OFFSET + VIDEO_IN_H - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             pos_sof;
    logic             pos_eol;
    logic             pos_eof;
    logic             in_win;
    logic             win_origin;
    logic             mid_sof;
    logic             pass_thru;
    logic             out_hs;
    logic             cnt_clear;

    assign in_win     = (h_cnt >= H_LO) && (h_cnt <= H_HI) && (v_cnt >= V_LO) && (v_cnt <= V_HI);
    assign win_origin = (h_cnt == H_LO) && (v_cnt == V_LO);
    // an SOF anywhere inside the window except its origin means the source restarted
    assign mid_sof    = (state == ST_FRAME) && in_win && !win_origin && s_axis_tvalid && s_axis_tuser[0];
    assign pass_thru  = (state == ST_FRAME) && in_win && !mid_sof;
    assign out_hs     = m_axis_tvalid && m_axis_tready;
    assign cnt_clear  = (state == ST_IDLE) && s_axis_tvalid && s_axis_tuser[0];

    axis_video_raster_cnt #(
        .OUT_W (VIDEO_OUT_W),
        .OUT_H (VIDEO_OUT_H)
    ) u_raster (
        .clk     (axis_clk),
        .rst_n   (aresetn),
        .advance (out_hs),
        .clear   (cnt_clear),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .sof     (pos_sof),
        .eol     (pos_eol),
        .eof     (pos_eof)
    );

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        s_axis_tready = 1'b0;
        case (state)
            ST_IDLE: begin
                s_axis_tready = s_axis_tvalid && !s_axis_tuser[0];
            end
            ST_FRAME, ST_FLUSH: begin
                m_axis_tlast    = pos_eol;
                m_axis_tuser[0] = pos_sof;
                if (pass_thru) begin
                    m_axis_tvalid = s_axis_tvalid;
                    m_axis_tdata  = s_axis_tdata;
                    s_axis_tready = m_axis_tready;
                end else begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = BORDER_COLOR;
                end
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cnt_clear) state_nxt = ST_FRAME;
            end
            ST_FRAME: begin
                if (mid_sof) state_nxt = ST_FLUSH;
                if (out_hs && pos_eof) state_nxt = ST_IDLE;
            end
            ST_FLUSH: begin
                if (out_hs && pos_eof) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

`ifdef AXIS_VIDEO_PAD_STATUS_EN
    logic frame_end;
    logic win_beat;

    assign frame_end = out_hs && pos_eof;
    assign win_beat  = pass_thru && s_axis_tvalid && s_axis_tready;

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt  <= '0;
            resync_cnt <= '0;
            tlast_err  <= 1'b0;
        end else begin
            if (frame_end) frame_cnt <= frame_cnt + 16'd1;
            if ((state == ST_FRAME) && (state_nxt == ST_FLUSH)) resync_cnt <= resync_cnt + 16'd1;
            if (win_beat && (s_axis_tlast != (h_cnt == H_HI))) tlast_err <= 1'b1;
        end
    end
`else
    logic unused_in;
    assign unused_in = ^{s_axis_tlast, s_axis_tuser};
`endif

endmodule

// File: tb/tb_axis_video_pad.sv
// tb/tb_axis_video_pad.sv - directed bench for axis_video_pad on an 8x6 canvas with a 4x2 window
module tb_axis_video_pad;

    localparam logic [23:0] BC = 24'hABCDEF;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } beat_t;

    logic        axis_clk = 1'b0;
    logic        aresetn  = 1'b0;
    logic [23:0] s_axis_tdata  = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast  = 1'b0;
    logic [0:0]  s_axis_tuser  = '0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
`ifdef AXIS_VIDEO_PAD_STATUS_EN
    logic [15:0] frame_cnt;
    logic [15:0] resync_cnt;
    logic        tlast_err;
`endif

    always #5 axis_clk = ~axis_clk;

    axis_video_pad #(
        .VIDEO_IN_W   (4),
        .VIDEO_IN_H   (2),
        .VIDEO_OUT_W  (8),
        .VIDEO_OUT_H  (6),
        .H_OFFSET     (2),
        .V_OFFSET     (3),
        .DATA_WIDTH   (24),
        .USER_WIDTH   (1),
        .BORDER_COLOR (BC)
    ) dut (
        .axis_clk      (axis_clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
`ifdef AXIS_VIDEO_PAD_STATUS_EN
        ,
        .frame_cnt     (frame_cnt),
        .resync_cnt    (resync_cnt),
        .tlast_err     (tlast_err)
`endif
    );

    beat_t src_q[$];
    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    out_beats   = 0;
    int    rdy_pct     = 100;
    int    gap_pct     = 0;
    logic  s_hs        = 1'b0;
    logic  stall_prev  = 1'b0;
    beat_t prev_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [23:0] base, input int bad_last);
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.d = base + 24'(i + 1);
            b.u = (i == 0);
            b.l = (i == 7) || ((bad_last < 0) ? (i == 3) : (i == bad_last));
            src_q.push_back(b);
        end
    endtask

    task automatic push_junk(input logic [23:0] val);
        beat_t b;
        b.d = val;
        b.u = 1'b0;
        b.l = 1'b0;
        src_q.push_back(b);
    endtask

    // valid_px limits how many window pixels carry data before the rest turns to border
    task automatic push_expect(input logic [23:0] base, input int valid_px);
        beat_t b;
        int h, v, p;
        logic win;
        for (int idx = 0; idx < 48; idx++) begin
            h   = idx % 8;
            v   = idx / 8;
            win = (h >= 2) && (h < 6) && (v >= 3) && (v < 5);
            p   = (v - 3) * 4 + (h - 2);
            b.d = (win && p < valid_px) ? base + 24'(p + 1) : BC;
            b.u = (idx == 0);
            b.l = (h == 7);
            exp_q.push_back(b);
        end
    endtask

    task automatic cycle();
        beat_t e;
        @(negedge axis_clk);
        if (s_hs) begin
            void'(src_q.pop_front());
            s_axis_tvalid = 1'b0;
            s_hs = 1'b0;
        end
        if (!s_axis_tvalid && src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = src_q[0].d;
            s_axis_tuser  = src_q[0].u;
            s_axis_tlast  = src_q[0].l;
        end
        m_axis_tready = ($urandom_range(99) < rdy_pct);
        #1;
        if (stall_prev) begin
            check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("stall_tdata",  32'(m_axis_tdata), 32'(prev_out.d));
            check("stall_tuser",  32'(m_axis_tuser), 32'(prev_out.u));
            check("stall_tlast",  32'(m_axis_tlast), 32'(prev_out.l));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("beat%0d_tdata", out_beats), 32'(m_axis_tdata), 32'(e.d));
                check($sformatf("beat%0d_tuser", out_beats), 32'(m_axis_tuser), 32'(e.u));
                check($sformatf("beat%0d_tlast", out_beats), 32'(m_axis_tlast), 32'(e.l));
            end
            out_beats++;
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_out.d = m_axis_tdata;
        prev_out.u = m_axis_tuser[0];
        prev_out.l = m_axis_tlast;
        s_hs = s_axis_tvalid && s_axis_tready;
    endtask

    task automatic run_frames(input string tag, input int max_cycles);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            cycle();
            n++;
        end
        check({tag, "_done"}, 32'(exp_q.size()), 32'd0);
        cycle();
        check({tag, "_src_drained"}, 32'(src_q.size()), 32'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge axis_clk);
        #1;
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_m_tlast",  32'(m_axis_tlast), 32'd0);
        check("rst_m_tuser",  32'(m_axis_tuser), 32'd0);
        check("rst_m_tdata",  32'(m_axis_tdata), 32'd0);
`ifdef AXIS_VIDEO_PAD_STATUS_EN
        check("rst_frame_cnt",  32'(frame_cnt), 32'd0);
        check("rst_resync_cnt", 32'(resync_cnt), 32'd0);
        check("rst_tlast_err",  32'(tlast_err), 32'd0);
`endif
        @(negedge axis_clk);
        aresetn = 1'b1;
        cycle();
        check("idle_m_tvalid", 32'(m_axis_tvalid), 32'd0);

        // 1: ready held high, one clean frame
        push_frame(24'h000000, -1);
        push_expect(24'h000000, 8);
        run_frames("t1_plain", 200);

        // 2: random backpressure and source gaps
        rdy_pct = 50;
        gap_pct = 30;
        push_frame(24'h000010, -1);
        push_expect(24'h000010, 8);
        run_frames("t2_random", 1000);
        rdy_pct = 100;
        gap_pct = 0;

        // 3: stale non-SOF beats are dropped in idle
        push_junk(24'h0000E1);
        push_junk(24'h0000E2);
        push_junk(24'h0000E3);
        push_frame(24'h000020, -1);
        push_expect(24'h000020, 8);
        run_frames("t3_stale", 200);

        // 4: new SOF at the fourth input pixel flushes the rest of the frame
        push_frame(24'h000100, -1);
        void'(src_q.pop_back());
        void'(src_q.pop_back());
        void'(src_q.pop_back());
        void'(src_q.pop_back());
        void'(src_q.pop_back());
        push_frame(24'h000200, -1);
        push_expect(24'h000100, 3);
        push_expect(24'h000200, 8);
        run_frames("t4_resync", 400);
`ifdef AXIS_VIDEO_PAD_STATUS_EN
        check("t4_resync_cnt", 32'(resync_cnt), 32'd1);
        check("t4_frame_cnt",  32'(frame_cnt), 32'd5);
`endif

        // 5: asynchronous reset at output beat 20
        out_beats = 0;
        push_frame(24'h000300, -1);
        push_expect(24'h000300, 8);
        for (int n = 0; n < 200 && out_beats < 20; n++) cycle();
        check("t5_reached_beat20", 32'(out_beats), 32'd20);
        @(negedge axis_clk);
        #1;
        check("t5_pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        check("t5_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t5_rst_tdata",  32'(m_axis_tdata), 32'd0);
        src_q.delete();
        exp_q.delete();
        s_axis_tvalid = 1'b0;
        s_hs = 1'b0;
        stall_prev = 1'b0;
        @(negedge axis_clk);
        aresetn = 1'b1;
        push_frame(24'h000400, -1);
        push_expect(24'h000400, 8);
        run_frames("t5_after_rst", 200);
`ifdef AXIS_VIDEO_PAD_STATUS_EN
        check("t5_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t5_tlast_err", 32'(tlast_err), 32'd0);
`endif

        // 6: input tlast on the wrong pixel does not disturb framing
        push_frame(24'h000500, 1);
        push_expect(24'h000500, 8);
        run_frames("t6_bad_tlast", 200);
`ifdef AXIS_VIDEO_PAD_STATUS_EN
        check("t6_tlast_err", 32'(tlast_err), 32'd1);
        check("t6_frame_cnt", 32'(frame_cnt), 32'd2);
        repeat (3) cycle();
        check("t6_tlast_err_sticky", 32'(tlast_err), 32'd1);
`endif
        check("final_idle_tvalid", 32'(m_axis_tvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_video_pad.md
Name: axis_video_pad

Overview:
- Inverse of the team's AXIS crop stage: embeds a VIDEO_IN_W x VIDEO_IN_H input frame into a larger VIDEO_OUT_W x VIDEO_OUT_H output canvas at (H_OFFSET, V_OFFSET).
- All pixels outside the input window carry BORDER_COLOR.
- Sits between a small-frame source (crop or test generator) and the full-resolution DMA/DisplayPort path.
- Output is a regular AXI4-Stream video frame: tuser marks start of frame, tlast marks end of line.

Parameters:
- VIDEO_IN_W, 640: input frame width (pixels).
- VIDEO_IN_H, 480: input frame height (lines).
- VIDEO_OUT_W, 1920: output canvas width.
- VIDEO_OUT_H, 1080: output canvas height.
- H_OFFSET, 640: first output column of the input window. Requires H_OFFSET+VIDEO_IN_W <= VIDEO_OUT_W.
- V_OFFSET, 300: first output line of the input window. Requires V_OFFSET+VIDEO_IN_H <= VIDEO_OUT_H.
- DATA_WIDTH, 24: pixel width.
- USER_WIDTH, 1: tuser width; bit 0 is SOF, upper bits are driven 0.
- BORDER_COLOR, 24'h000000: border pixel value, DATA_WIDTH bits.

Ports:
- axis_clk  in  1  single clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end-of-line.
- s_axis_tuser  in  USER_WIDTH  input SOF (bit 0).
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end-of-line.
- m_axis_tuser  out  USER_WIDTH  output SOF.

Behaviour:
- Registered state:
  - h_cnt: 16 bits, 0..VIDEO_OUT_W-1.
  - v_cnt: 16 bits, 0..VIDEO_OUT_H-1.
  - state: IDLE / FRAME / FLUSH.
  - All reset asynchronously to 0 / IDLE.
- Reset-time output values: m_axis_tvalid=0, s_axis_tready=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0.
- in_win = (h_cnt in [H_OFFSET, H_OFFSET+VIDEO_IN_W)) and (v_cnt in [V_OFFSET, V_OFFSET+VIDEO_IN_H)).
- IDLE:
  - m_axis_tvalid=0.
  - s_axis_tready=1 only while s_axis_tvalid=1 and s_axis_tuser[0]=0. Stale mid-frame input is discarded.
  - An input beat with tuser[0]=1 is not consumed. Next cycle: state=FRAME with h_cnt=v_cnt=0.
- FRAME, border pixel (!in_win):
  - m_axis_tvalid=1, m_axis_tdata=BORDER_COLOR, s_axis_tready=0.
- FRAME, window pixel (in_win), zero-latency pass-through:
  - m_axis_tvalid=s_axis_tvalid, m_axis_tdata=s_axis_tdata, s_axis_tready=m_axis_tready.
- Output sideband, combinational from the counters in every FRAME/FLUSH beat:
  - m_axis_tuser[0] = (h_cnt==0 && v_cnt==0).
  - m_axis_tlast = (h_cnt==VIDEO_OUT_W-1).
- Counter advance: only on output handshake (m_axis_tvalid & m_axis_tready). h_cnt wraps at VIDEO_OUT_W-1 and increments v_cnt.
- End of frame: handshake at (VIDEO_OUT_W-1, VIDEO_OUT_H-1) -> state=IDLE. This gives at least one idle cycle between frames and re-synchronises on the next input SOF.
- Mid-frame input SOF (s_axis_tvalid & tuser[0] while in_win and not at window origin):
  - Beat is not consumed; state=FLUSH.
  - FLUSH emits BORDER_COLOR for every remaining pixel, including window positions, with s_axis_tready=0.
  - At end of frame -> IDLE, which then accepts the held SOF beat.
- Input tlast is ignored for framing; output line structure comes only from the counters.
- Backpressure: border pixels hold data and counters stable while m_axis_tready=0. Output AXIS stability rules hold by construction.
- Reset mid-frame: output drops immediately (asynchronous). After release, the block waits in IDLE for the next input SOF.

Optional Feature:
- Macro: AXIS_VIDEO_PAD_STATUS_EN.
- Defined: adds three outputs.
  - frame_cnt[15:0]: increments at each end of frame.
  - resync_cnt[15:0]: increments on each FRAME->FLUSH transition.
  - tlast_err: sticky 1-bit flag, cleared only by reset. Set when a consumed input beat has s_axis_tlast != (h_cnt==H_OFFSET+VIDEO_IN_W-1).
  - All three reset to 0; counters wrap at 16 bits.
- Undefined: these ports and their logic are absent. Datapath behaviour is identical either way.

Decomposition:
- Shared package axis_video_pkg:
  - State encoding (IDLE/FRAME/FLUSH).
  - Counter width constant CNT_W=16.
  - Shared with the crop stage and future video blocks.
- One natural sub-module: axis_video_raster_cnt. Holds the h/v counters with advance/clear inputs plus sof, eol and eof decodes; reusable by the crop stage.

Test Plan (OUT 8x6, IN 4x2, H_OFFSET=2, V_OFFSET=3, BORDER_COLOR=24'hABCDEF):
- Ready held 1; input frame 0x000001..0x000008 with SOF on the first beat -> 48 output beats.
  - Beats at (h2..5, v3..4) carry 1..8; the rest carry ABCDEF.
  - tuser only on beat 0; tlast on beats 7, 15, ..., 47.
- Random m_axis_tready 50% and random s_axis_tvalid gaps -> same 48-beat sequence; tdata/tuser/tlast stable while stalled.
- Three non-SOF input beats before SOF -> all three consumed and dropped; output starts only after SOF.
- New SOF injected at input pixel 3 -> remainder of frame is ABCDEF; the following frame carries the new data correctly (resync_cnt=1 with macro).
- aresetn pulsed low at output beat 20 -> m_axis_tvalid=0 that cycle; next frame is clean from (0,0).
- Macro on: input tlast on pixel 2 instead of 4 -> tlast_err=1 and stays 1; frame_cnt=2 after two frames.
